// File: rtl/sync_debounce_edge_if.sv
// Level/strobe bundle for the per-bit debounce and edge detector.
// The slave side is the filter; the master side drives din/flag_clr.
interface sync_debounce_edge_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] flag_clr;
   logic [WIDTH-1:0] dout;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] rise_flag;
   logic [WIDTH-1:0] fall_flag;
   logic             any_event;

   modport master (
      output din, flag_clr,
      input  dout, rise, fall,
      input  rise_flag, fall_flag, any_event
   );

   modport slave (
      input  din, flag_clr,
      output dout, rise, fall,
      output rise_flag, fall_flag, any_event
   );
endinterface

// File: rtl/sync_debounce_edge.sv
// Per-bit glitch filter with registered rise/fall strobes
// and software-cleared sticky event flags.
module sync_debounce_edge #(
   parameter int WIDTH         = 1,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   sync_debounce_edge_if.slave   bus
);
   localparam int SC = (STABLE_CYCLES < 1)     ? 1 :
                       (STABLE_CYCLES > 65535) ? 65535 :
                       STABLE_CYCLES;
   localparam int CW = (SC > 1) ? $clog2(SC) : 1;
   localparam logic [CW-1:0] LAST = CW'(SC - 1);

   logic [WIDTH-1:0]         level_q, level_d;
   logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]         rise_q, rise_d;
   logic [WIDTH-1:0]         fall_q, fall_d;
   logic [WIDTH-1:0]         rise_flag_q, rise_flag_d;
   logic [WIDTH-1:0]         fall_flag_q, fall_flag_d;
   logic                     any_event_q, any_event_d;

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      rise_d  = '0;
      fall_d  = '0;
      // any sample matching the level restarts the count
      for (int i = 0; i < WIDTH; i++) begin
         if (bus.din[i] != level_q[i]) begin
            if (cnt_q[i] == LAST) begin
               level_d[i] = bus.din[i];
               rise_d[i]  = bus.din[i];
               fall_d[i]  = ~bus.din[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
      // a new event wins over a same-cycle clear
      rise_flag_d = rise_d | (rise_flag_q & ~bus.flag_clr);
      fall_flag_d = fall_d | (fall_flag_q & ~bus.flag_clr);
      any_event_d = |(rise_d | fall_d);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         level_q     <= '0;
         cnt_q       <= '0;
         rise_q      <= '0;
         fall_q      <= '0;
         rise_flag_q <= '0;
         fall_flag_q <= '0;
         any_event_q <= 1'b0;
      end else begin
         level_q     <= level_d;
         cnt_q       <= cnt_d;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
         rise_flag_q <= rise_flag_d;
         fall_flag_q <= fall_flag_d;
         any_event_q <= any_event_d;
      end
   end

   assign bus.dout      = level_q;
   assign bus.rise      = rise_q;
   assign bus.fall      = fall_q;
   assign bus.rise_flag = rise_flag_q;
   assign bus.fall_flag = fall_flag_q;
   assign bus.any_event = any_event_q;
endmodule

// File: tb/tb_sync_debounce_edge.sv
// Bench for sync_debounce_edge: directed scenarios on a 2-bit/4-cycle
// and a 1-bit/1-cycle instance, plus random traffic against a window model.
module tb_sync_debounce_edge;
   localparam int SA = 4;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   errors = 0;
   int   checks = 0;

   sync_debounce_edge_if #(.WIDTH(2)) if_a ();
   sync_debounce_edge_if #(.WIDTH(1)) if_b ();

   sync_debounce_edge #(.WIDTH(2), .STABLE_CYCLES(SA)) dut_a (
      .clk    (clk),
      .resetn (resetn),
      .bus    (if_a)
   );

   sync_debounce_edge #(.WIDTH(1), .STABLE_CYCLES(1)) dut_b (
      .clk    (clk),
      .resetn (resetn),
      .bus    (if_b)
   );

   always #5 clk = ~clk;

   // window model: flip when the last SA samples all differ from the level
   bit [1:0] m_lvl, m_r, m_f, m_rf, m_ff;
   bit       m_ae;
   bit       hist0[$];
   bit       hist1[$];

   task automatic model_reset();
      m_lvl = 0; m_r = 0; m_f = 0; m_rf = 0; m_ff = 0; m_ae = 0;
      hist0.delete();
      hist1.delete();
   endtask

   task automatic model_step(input bit [1:0] d, input bit [1:0] clr);
      bit all_diff;
      bit [1:0] nr, nf;
      nr = 0; nf = 0;
      hist0.push_back(d[0]);
      if (hist0.size() > SA) void'(hist0.pop_front());
      hist1.push_back(d[1]);
      if (hist1.size() > SA) void'(hist1.pop_front());
      for (int b = 0; b < 2; b++) begin
         all_diff = ((b == 0 ? hist0.size() : hist1.size()) == SA);
         for (int k = 0; k < SA && all_diff; k++)
            if ((b == 0 ? hist0[k] : hist1[k]) == m_lvl[b]) all_diff = 0;
         if (all_diff) begin
            m_lvl[b] = d[b];
            nr[b] = d[b];
            nf[b] = ~d[b];
         end
      end
      m_r  = nr;
      m_f  = nf;
      m_rf = nr | (m_rf & ~clr);
      m_ff = nf | (m_ff & ~clr);
      m_ae = |(nr | nf);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      resetn = 1'b0;
      if_a.din = 0; if_a.flag_clr = 0;
      if_b.din = 0; if_b.flag_clr = 0;
      tick(2);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      if_a.din = 0; if_a.flag_clr = 0;
      if_b.din = 0; if_b.flag_clr = 0;
      tick(2);
      checks++;
      if ({if_a.dout, if_a.rise, if_a.fall, if_a.rise_flag,
           if_a.fall_flag, if_a.any_event} !== 11'd0) begin
         errors++;
         $display("FAIL reset_a: got %b want 0", {if_a.dout, if_a.rise,
                  if_a.fall, if_a.rise_flag, if_a.fall_flag, if_a.any_event});
      end
      checks++;
      if ({if_b.dout, if_b.rise, if_b.fall, if_b.rise_flag,
           if_b.fall_flag, if_b.any_event} !== 6'd0) begin
         errors++;
         $display("FAIL reset_b: got %b want 0", {if_b.dout, if_b.rise,
                  if_b.fall, if_b.rise_flag, if_b.fall_flag, if_b.any_event});
      end
      resetn = 1'b1;
   endtask

   task automatic test_rise();
      apply_reset();
      tick(5);
      if_a.din = 2'b01;
      tick(3);
      checks++;
      if (if_a.dout !== 2'b00 || if_a.rise !== 2'b00) begin
         errors++;
         $display("FAIL rise_early: dout=%b rise=%b want 00 00",
                  if_a.dout, if_a.rise);
      end
      tick(1);
      checks++;
      if (if_a.dout !== 2'b01 || if_a.rise !== 2'b01 ||
          if_a.rise_flag !== 2'b01 || if_a.any_event !== 1'b1 ||
          if_a.fall !== 2'b00) begin
         errors++;
         $display("FAIL rise_pulse: dout=%b rise=%b rf=%b ae=%b fall=%b",
                  if_a.dout, if_a.rise, if_a.rise_flag, if_a.any_event,
                  if_a.fall);
      end
      tick(1);
      checks++;
      if (if_a.rise !== 2'b00 || if_a.any_event !== 1'b0 ||
          if_a.rise_flag !== 2'b01 || if_a.dout !== 2'b01) begin
         errors++;
         $display("FAIL rise_after: rise=%b ae=%b rf=%b dout=%b",
                  if_a.rise, if_a.any_event, if_a.rise_flag, if_a.dout);
      end
   endtask

   task automatic test_glitch();
      apply_reset();
      if_a.din = 2'b10;
      tick(3);
      if_a.din = 2'b00;
      tick(1);
      checks++;
      if (if_a.dout !== 2'b00 || if_a.rise !== 2'b00 ||
          if_a.rise_flag !== 2'b00 || if_a.fall_flag !== 2'b00) begin
         errors++;
         $display("FAIL glitch3: dout=%b rise=%b rf=%b ff=%b want 0",
                  if_a.dout, if_a.rise, if_a.rise_flag, if_a.fall_flag);
      end
      if_a.din = 2'b10;
      tick(4);
      checks++;
      if (if_a.rise !== 2'b10 || if_a.dout !== 2'b10) begin
         errors++;
         $display("FAIL glitch4: rise=%b dout=%b want 10 10",
                  if_a.rise, if_a.dout);
      end
      if_a.din = 2'b00;
   endtask

   task automatic test_fall_clear();
      apply_reset();
      if_a.din = 2'b11;
      tick(5);
      if_a.din = 2'b10;
      tick(3);
      checks++;
      if (if_a.dout !== 2'b11 || if_a.fall !== 2'b00) begin
         errors++;
         $display("FAIL fall_early: dout=%b fall=%b want 11 00",
                  if_a.dout, if_a.fall);
      end
      tick(1);
      checks++;
      if (if_a.dout !== 2'b10 || if_a.fall !== 2'b01 ||
          if_a.fall_flag !== 2'b01 || if_a.any_event !== 1'b1) begin
         errors++;
         $display("FAIL fall_pulse: dout=%b fall=%b ff=%b ae=%b",
                  if_a.dout, if_a.fall, if_a.fall_flag, if_a.any_event);
      end
      tick(1);
      if_a.flag_clr = 2'b01;
      tick(1);
      if_a.flag_clr = 2'b00;
      checks++;
      if (if_a.fall_flag !== 2'b00 || if_a.rise_flag !== 2'b10) begin
         errors++;
         $display("FAIL fall_clear: ff=%b rf=%b want 00 10",
                  if_a.fall_flag, if_a.rise_flag);
      end
      tick(1);
      checks++;
      if (if_a.fall_flag !== 2'b00 || if_a.rise_flag !== 2'b10) begin
         errors++;
         $display("FAIL clr_idle: ff=%b rf=%b want 00 10",
                  if_a.fall_flag, if_a.rise_flag);
      end
   endtask

   task automatic test_collision();
      apply_reset();
      if_a.flag_clr = 2'b01;
      if_a.din = 2'b01;
      tick(4);
      checks++;
      if (if_a.rise !== 2'b01 || if_a.rise_flag !== 2'b01) begin
         errors++;
         $display("FAIL collide_set: rise=%b rf=%b want 01 01",
                  if_a.rise, if_a.rise_flag);
      end
      tick(1);
      checks++;
      if (if_a.rise_flag !== 2'b00) begin
         errors++;
         $display("FAIL collide_clr: rf=%b want 00", if_a.rise_flag);
      end
      if_a.flag_clr = 2'b00;
   endtask

   task automatic test_async_reset();
      apply_reset();
      if_a.din = 2'b10;
      if_b.din = 1'b1;
      tick(4);
      if_a.din = 2'b11;
      tick(2);
      #3;
      resetn = 1'b0;
      #1;
      checks++;
      if ({if_a.dout, if_a.rise, if_a.fall, if_a.rise_flag,
           if_a.fall_flag, if_a.any_event} !== 11'd0 ||
          if_b.dout !== 1'b0 || if_b.rise_flag !== 1'b0) begin
         errors++;
         $display("FAIL async_rst: a=%b b_dout=%b b_rf=%b want 0",
                  {if_a.dout, if_a.rise, if_a.fall, if_a.rise_flag,
                   if_a.fall_flag, if_a.any_event},
                  if_b.dout, if_b.rise_flag);
      end
      resetn = 1'b1;
      if_b.din = 1'b0;
      tick(3);
      checks++;
      if (if_a.dout !== 2'b00 || if_a.rise !== 2'b00) begin
         errors++;
         $display("FAIL rst_count: dout=%b rise=%b want 00 00",
                  if_a.dout, if_a.rise);
      end
      tick(1);
      checks++;
      if (if_a.dout !== 2'b11 || if_a.rise !== 2'b11) begin
         errors++;
         $display("FAIL rst_release: dout=%b rise=%b want 11 11",
                  if_a.dout, if_a.rise);
      end
      if_a.din = 2'b00;
   endtask

   task automatic test_pass_through();
      bit v;
      apply_reset();
      v = 1'b0;
      for (int i = 0; i < 8; i++) begin
         v = ~v;
         if_b.din = v;
         tick(1);
         checks++;
         if (if_b.dout !== v || if_b.rise !== v || if_b.fall !== ~v ||
             if_b.any_event !== 1'b1) begin
            errors++;
            $display("FAIL pass_%0d: dout=%b rise=%b fall=%b ae=%b want %b",
                     i, if_b.dout, if_b.rise, if_b.fall, if_b.any_event, v);
         end
      end
      if_b.din = 1'b0;
   endtask

   task automatic test_random();
      int hold;
      bit [1:0] d, clr;
      apply_reset();
      model_reset();
      hold = 0;
      d = 0;
      for (int i = 0; i < 600; i++) begin
         if (hold == 0) begin
            d = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 6);
         end
         hold--;
         clr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         if_a.din = d;
         if_a.flag_clr = clr;
         @(posedge clk);
         model_step(d, clr);
         #1;
         checks++;
         if ({if_a.dout, if_a.rise, if_a.fall, if_a.rise_flag,
              if_a.fall_flag, if_a.any_event} !==
             {m_lvl, m_r, m_f, m_rf, m_ff, m_ae}) begin
            errors++;
            $display("FAIL random_%0d: got %b want %b", i,
                     {if_a.dout, if_a.rise, if_a.fall, if_a.rise_flag,
                      if_a.fall_flag, if_a.any_event},
                     {m_lvl, m_r, m_f, m_rf, m_ff, m_ae});
         end
      end
      if_a.flag_clr = 2'b00;
   endtask

   initial begin
      test_reset();
      test_rise();
      test_glitch();
      test_fall_clear();
      test_collision();
      test_async_reset();
      test_pass_through();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
